// File: rtl/div4_pkg.sv
// Shared types and width helpers for the div4 round-robin scheduler.
package div4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_e;

  // A single requester still needs a 1-bit ID so rsp_id_o never collapses to zero width.
  function automatic int id_width(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

  function automatic int cnt_width(input int div_lat);
    return (div_lat <= 1) ? 1 : $clog2(div_lat + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any
);

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/div4_rr_sched.sv
// Round-robin scheduler sharing one divide-by-4 unit between NUM_REQ requesters;
// one job in flight, result returned with the owner's ID over a valid/ready channel.
module div4_rr_sched
  import div4_pkg::*;
#(
  parameter  int WIDTH   = 4,
  parameter  int NUM_REQ = 4,
  parameter  int DIV_LAT = 1,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic                       div_en_o,
  output logic [WIDTH-1:0]           div_data_o,
  input  logic [WIDTH-1:0]           div_data_i,
  input  logic                       div_valid_i,
  output logic                       rsp_valid_o,
  output logic [WIDTH-1:0]           rsp_data_o,
  output logic [ID_W-1:0]            rsp_id_o,
  input  logic                       rsp_ready_i,
  output logic                       busy_o
);

  localparam int                CNT_W    = cnt_width(DIV_LAT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV_LAT - 1);
  localparam logic [ID_W-1:0]   ID_LAST  = ID_W'(NUM_REQ - 1);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    id_q;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   op_q;
  logic [WIDTH-1:0]   req_ops [NUM_REQ];
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;
  logic               cnt_last;
  logic               accept;
  logic               capture;
  logic               release_rsp;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      req_ops[k] = req_data_i[k*WIDTH +: WIDTH];
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid_i),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign cnt_last   = (cnt == CNT_LAST);
  assign busy_o     = (state_q != IDLE);
  assign div_data_o = op_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    div_en_o    = 1'b0;
    rsp_valid_o = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    release_rsp = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = grant;
        if (grant_any) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        div_en_o = 1'b1;
        if (cnt_last && div_valid_i) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          release_rsp = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The counter saturates at DIV_LAT-1 so a late div_valid_i simply extends RUN.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr     <= '0;
      id_q       <= '0;
      cnt        <= '0;
      op_q       <= '0;
      rsp_data_o <= '0;
      rsp_id_o   <= '0;
    end else begin
      if (accept) begin
        op_q <= req_ops[grant_idx];
        id_q <= grant_idx;
        cnt  <= '0;
      end else if (state_q == RUN && !cnt_last) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (capture) begin
        rsp_data_o <= div_data_i;
        rsp_id_o   <= id_q;
      end
      if (release_rsp) begin
        rr_ptr <= (id_q == ID_LAST) ? '0 : id_q + ID_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_div4_rr_sched.sv
// Self-checking bench: transaction-level reference model compared every cycle,
// directed literal scenarios, randomized traffic, and a DIV_LAT=3 stall instance.
module tb_div4_rr_sched;

  localparam int WIDTH     = 4;
  localparam int NUM_REQ   = 4;
  localparam int ID_W      = 2;
  localparam int LAT       = 1;
  localparam int STALL_LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     div_en;
  logic [WIDTH-1:0]         div_data_out;
  logic [WIDTH-1:0]         div_data_in;
  logic                     div_valid;
  logic                     rsp_valid;
  logic [WIDTH-1:0]         rsp_data;
  logic [ID_W-1:0]          rsp_id;
  logic                     rsp_ready;
  logic                     busy;

  logic                     s_rst;
  logic [NUM_REQ-1:0]       s_req_valid;
  logic [NUM_REQ*WIDTH-1:0] s_req_data;
  logic [NUM_REQ-1:0]       s_req_ready;
  logic                     s_div_en;
  logic [WIDTH-1:0]         s_div_data_out;
  logic [WIDTH-1:0]         s_div_data;
  logic                     s_div_valid;
  logic                     s_rsp_valid;
  logic [WIDTH-1:0]         s_rsp_data;
  logic [ID_W-1:0]          s_rsp_id;
  logic                     s_rsp_ready;
  logic                     s_busy;

  // The shared div4 unit attached to the main instance.
  assign div_data_in = div_data_out >> 2;

  div4_rr_sched #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .DIV_LAT(LAT)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready), .div_en_o(div_en), .div_data_o(div_data_out),
    .div_data_i(div_data_in), .div_valid_i(div_valid), .rsp_valid_o(rsp_valid),
    .rsp_data_o(rsp_data), .rsp_id_o(rsp_id), .rsp_ready_i(rsp_ready), .busy_o(busy)
  );

  div4_rr_sched #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .DIV_LAT(STALL_LAT)) dut_stall (
    .clk_i(clk), .rst_i(s_rst), .req_valid_i(s_req_valid), .req_data_i(s_req_data),
    .req_ready_o(s_req_ready), .div_en_o(s_div_en), .div_data_o(s_div_data_out),
    .div_data_i(s_div_data), .div_valid_i(s_div_valid), .rsp_valid_o(s_rsp_valid),
    .rsp_data_o(s_rsp_data), .rsp_id_o(s_rsp_id), .rsp_ready_i(s_rsp_ready), .busy_o(s_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding job record plus the held response and pointer.
  int         m_ptr         = 0;
  bit         m_active      = 1'b0;
  int         m_id          = 0;
  logic [3:0] m_op          = '0;
  int         m_age         = 0;
  bit         m_done        = 1'b0;
  logic [3:0] m_rsp_data    = '0;
  int         m_rsp_id      = 0;
  logic [3:0] m_div_last    = '0;
  int         m_last_accept = -1;

  function automatic int model_grant();
    for (int i = 0; i < NUM_REQ; i++) begin
      int k;
      k = (m_ptr + i) % NUM_REQ;
      if (req_valid[k]) return k;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    g = m_active ? -1 : model_grant();
    m_last_accept = -1;
    if (rst) begin
      m_ptr = 0; m_active = 1'b0; m_id = 0; m_op = '0; m_age = 0; m_done = 1'b0;
      m_rsp_data = '0; m_rsp_id = 0; m_div_last = '0;
    end else if (!m_active) begin
      if (g >= 0) begin
        m_active = 1'b1; m_id = g; m_op = req_data[g*WIDTH +: WIDTH];
        m_age = 0; m_done = 1'b0; m_div_last = m_op; m_last_accept = g;
      end
    end else if (!m_done) begin
      if (m_age >= LAT - 1 && div_valid) begin
        m_done = 1'b1; m_rsp_data = m_op / 4; m_rsp_id = m_id;
      end
      m_age++;
    end else if (rsp_ready) begin
      m_active = 1'b0;
      m_ptr    = (m_id + 1) % NUM_REQ;
    end
  end

  always @(negedge clk) begin
    logic [NUM_REQ-1:0] exp_ready;
    int g;
    if (cmp_en) begin
      exp_ready = '0;
      if (!m_active) begin
        g = model_grant();
        if (g >= 0) exp_ready[g] = 1'b1;
      end
      checkOutput("m req_ready", 32'(req_ready), 32'(exp_ready));
      checkOutput("m busy", 32'(busy), 32'(m_active));
      checkOutput("m div_en", 32'(div_en), 32'(m_active && !m_done));
      checkOutput("m div_data", 32'(div_data_out), 32'(m_div_last));
      checkOutput("m rsp_valid", 32'(rsp_valid), 32'(m_active && m_done));
      checkOutput("m rsp_data", 32'(rsp_data), 32'(m_rsp_data));
      checkOutput("m rsp_id", 32'(rsp_id), 32'(m_rsp_id));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic applyReset();
    rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b0; div_valid = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Requesters hold valid/data until the model says they were accepted.
  task automatic applyStimulus();
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!(req_valid[k] && m_last_accept != k)) begin
        if ($urandom_range(0, 3) == 0) begin
          req_valid[k] = 1'b1;
          req_data[k*WIDTH +: WIDTH] = 4'($urandom);
        end else begin
          req_valid[k] = 1'b0;
        end
      end
    end
    rsp_ready = ($urandom_range(0, 9) < 6);
    div_valid = ($urandom_range(0, 9) < 7);
    rst       = ($urandom_range(0, 299) == 0);
  endtask

  int exp_g[5]  = '{0, 1, 2, 3, 0};
  int exp_rd[4] = '{2, 3, 1, 3};
  int exp_ri[4] = '{0, 1, 2, 3};

  initial begin
    int gl[8];
    int ri[8];
    int rd[8];
    int gn;
    int rn;
    int en_cnt;

    s_rst = 1'b1; s_req_valid = '0; s_req_data = '0; s_div_data = '0;
    s_div_valid = 1'b0; s_rsp_ready = 1'b0;
    applyReset();
    s_rst  = 1'b0;
    cmp_en = 1'b1;
    $display("[TB] reset values");
    settle();
    checkOutput("rst req_ready", 32'(req_ready), 0);
    checkOutput("rst div_en", 32'(div_en), 0);
    checkOutput("rst div_data", 32'(div_data_out), 0);
    checkOutput("rst rsp_valid", 32'(rsp_valid), 0);
    checkOutput("rst rsp_data", 32'(rsp_data), 0);
    checkOutput("rst rsp_id", 32'(rsp_id), 0);
    checkOutput("rst busy", 32'(busy), 0);

    $display("[TB] single request");
    req_valid = 4'b0100; req_data = 16'h0D00; rsp_ready = 1'b1; div_valid = 1'b1;
    settle();
    checkOutput("single accept", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    settle();
    checkOutput("single div_en", 32'(div_en), 1);
    checkOutput("single div_data", 32'(div_data_out), 32'hD);
    checkOutput("single no early rsp", 32'(rsp_valid), 0);
    tick();
    settle();
    checkOutput("single rsp_valid", 32'(rsp_valid), 1);
    checkOutput("single rsp_data", 32'(rsp_data), 3);
    checkOutput("single rsp_id", 32'(rsp_id), 2);
    tick();
    settle();
    checkOutput("single idle", 32'(busy), 0);

    $display("[TB] round robin");
    applyReset();
    gn = 0; rn = 0;
    for (int i = 0; i < 8; i++) begin gl[i] = -1; rd[i] = -1; ri[i] = -1; end
    req_valid = 4'hF; req_data = 16'hF4C8; rsp_ready = 1'b1; div_valid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      settle();
      for (int k = 0; k < NUM_REQ; k++) begin
        if (req_ready[k] && gn < 8) begin gl[gn] = k; gn++; end
      end
      if (rsp_valid && rn < 8) begin rd[rn] = int'(rsp_data); ri[rn] = int'(rsp_id); rn++; end
      tick();
    end
    req_valid = '0;
    tick(); tick(); tick();
    checkOutput("rr grant count", gn, 5);
    checkOutput("rr rsp count", rn, 4);
    for (int i = 0; i < 5; i++) checkOutput("rr grant order", gl[i], exp_g[i]);
    for (int i = 0; i < 4; i++) begin
      checkOutput("rr rsp data", rd[i], exp_rd[i]);
      checkOutput("rr rsp id", ri[i], exp_ri[i]);
    end

    $display("[TB] response backpressure");
    applyReset();
    req_valid = 4'b0010; req_data = 16'h0090; rsp_ready = 1'b0;
    settle();
    checkOutput("bp accept", 32'(req_ready), 32'h2);
    tick();
    tick();
    req_valid = 4'b0001; req_data = 16'h0007;
    for (int i = 0; i < 5; i++) begin
      settle();
      checkOutput("bp rsp_valid", 32'(rsp_valid), 1);
      checkOutput("bp rsp_data", 32'(rsp_data), 2);
      checkOutput("bp rsp_id", 32'(rsp_id), 1);
      checkOutput("bp no ready", 32'(req_ready), 0);
      tick();
    end
    rsp_ready = 1'b1;
    settle();
    checkOutput("bp same-cycle no accept", 32'(req_ready), 0);
    tick();
    rsp_ready = 1'b0;
    settle();
    checkOutput("bp next accept", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    settle();
    checkOutput("bp next op", 32'(div_data_out), 32'h7);
    tick();
    rsp_ready = 1'b1;
    tick();

    $display("[TB] pointer wrap and mid-run reset");
    applyReset();
    req_valid = 4'b1000; req_data = 16'hB000; rsp_ready = 1'b1;
    settle();
    checkOutput("wrap accept 3", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'b1001; req_data = 16'hB00C;
    tick();
    settle();
    checkOutput("wrap rsp_id", 32'(rsp_id), 3);
    checkOutput("wrap rsp_data", 32'(rsp_data), 2);
    tick();
    settle();
    checkOutput("wrap grant 0", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0; rst = 1'b1;
    settle();
    checkOutput("mid-run div_en", 32'(div_en), 1);
    checkOutput("mid-run div_data", 32'(div_data_out), 32'hC);
    tick();
    rst = 1'b0;
    settle();
    checkOutput("post-rst req_ready", 32'(req_ready), 0);
    checkOutput("post-rst div_en", 32'(div_en), 0);
    checkOutput("post-rst div_data", 32'(div_data_out), 0);
    checkOutput("post-rst rsp_valid", 32'(rsp_valid), 0);
    checkOutput("post-rst rsp_data", 32'(rsp_data), 0);
    checkOutput("post-rst rsp_id", 32'(rsp_id), 0);
    checkOutput("post-rst busy", 32'(busy), 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      settle();
      checkOutput("dropped job no rsp", 32'(rsp_valid), 0);
    end

    $display("[TB] random traffic");
    applyReset();
    for (int c = 0; c < 3000; c++) begin
      applyStimulus();
      tick();
    end
    rst = 1'b0; req_valid = '0; rsp_ready = 1'b1; div_valid = 1'b1;
    repeat (8) tick();

    $display("[TB] stall with DIV_LAT=3");
    s_req_valid = 4'b0100; s_req_data = 16'h0600; s_div_valid = 1'b0; s_rsp_ready = 1'b0;
    settle();
    checkOutput("stall accept", 32'(s_req_ready), 32'h4);
    en_cnt = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      s_req_valid = '0;
      s_div_data  = 4'(c);
      s_div_valid = (c == 5);
      settle();
      en_cnt += int'(s_div_en);
      if (c <= 5) checkOutput("stall div_data", 32'(s_div_data_out), 32'h6);
      if (c == 5) checkOutput("stall no early rsp", 32'(s_rsp_valid), 0);
      if (c == 6) begin
        checkOutput("stall rsp_valid", 32'(s_rsp_valid), 1);
        checkOutput("stall rsp_data", 32'(s_rsp_data), 5);
        checkOutput("stall rsp_id", 32'(s_rsp_id), 2);
        checkOutput("stall busy", 32'(s_busy), 1);
      end
    end
    checkOutput("stall div_en cycles", en_cnt, 5);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
